// File: rtl/mem_port_arbiter.sv
// Shared memory-port sequencer for the fetch and data stages: grants one request
// at a time, drives a fixed-latency single-port RAM, and returns aligned load data.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        dm_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr_data;
  logic        r_sel_dm;
  logic        r_rw;
  logic        r_err;
  logic [1:0]  r_size;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_grant_dm;
  logic        w_grant_if;
  logic        w_bad;
  logic [3:0]  w_be_dm;
  logic [31:0] w_wdata_dm;
  logic [31:0] w_load;

  // Data wins when it is the only requester or when the pointer favours it.
  assign w_grant_dm = (r_state == IDLE) & dm_req & (~if_req | r_ptr_data);
  assign w_grant_if = (r_state == IDLE) & if_req & ~w_grant_dm;
  assign w_bad      = (dm_size == 2'b11) | ((dm_size == 2'b01) & dm_addr[0]) |
                      ((dm_size == 2'b10) & (dm_addr[1:0] != 2'b00));

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_be_dm    = 4'b1111;
    w_wdata_dm = dm_wdata;
    case (dm_size)
      2'b00: begin
        w_be_dm    = 4'b0001 << dm_addr[1:0];
        w_wdata_dm = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        w_be_dm    = dm_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_dm = {2{dm_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_load = ram_rdata;
    case (r_size)
      2'b00:   w_load = {24'b0, ram_rdata[{r_addr[1:0], 3'b000} +: 8]};
      2'b01:   w_load = r_addr[1] ? {16'b0, ram_rdata[31:16]} : {16'b0, ram_rdata[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_dm)      w_next = w_bad ? RESP : ACCESS;
        else if (w_grant_if) w_next = ACCESS;
      end
      ACCESS:  if (r_cnt == 3'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr_data <= 1'b1;
      r_sel_dm   <= 1'b0;
      r_rw       <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_cnt      <= 3'd0;
      r_addr     <= 32'b0;
      r_be       <= 4'b0;
      r_wdata    <= 32'b0;
      r_if_rdata <= 32'b0;
      r_dm_rdata <= 32'b0;
    end else begin
      if (w_grant_dm || w_grant_if) begin
        r_ptr_data <= w_grant_if;
        r_sel_dm   <= w_grant_dm;
        r_rw       <= w_grant_dm & dm_rw;
        r_err      <= w_grant_dm & w_bad;
        r_size     <= w_grant_dm ? dm_size : 2'b10;
        r_addr     <= w_grant_dm ? dm_addr : {if_addr[31:2], 2'b00};
        r_be       <= w_grant_dm ? w_be_dm : 4'b1111;
        r_wdata    <= w_grant_dm ? w_wdata_dm : 32'b0;
        r_cnt      <= CNT_LOAD;
      end else if (r_state == ACCESS) begin
        if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end else if (!r_rw) begin
          if (r_sel_dm) r_dm_rdata <= w_load;
          else          r_if_rdata <= ram_rdata;
        end
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_done   = (r_state == RESP) & ~r_sel_dm;
  assign dm_done   = (r_state == RESP) & r_sel_dm;
  assign dm_err    = dm_done & r_err;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;
  // Enables come straight from the state register, so reset drops them asynchronously.
  assign ram_en    = (r_state == ACCESS);
  assign ram_we    = ram_en & r_rw;
  assign ram_be    = r_be;
  assign ram_addr  = {r_addr[31:2], 2'b00};
  assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a word-array reference memory and a small arbitration model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_rw;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic        dm_stall;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behavioural model: 1 KiB, combinational read, byte-lane writes on each ACCESS edge.
  logic [31:0] mem [256];
  logic        init_req;
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
    end else if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end else if (ram_en && ram_we) begin
      for (int k = 0; k < 4; k++)
        if (ram_be[k]) mem[ram_addr[9:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Reference model state.
  logic [31:0] exp_mem [256];
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;
  logic        m_ptr_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic is_bad(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] exp_lanes(input logic [1:0] s, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (s == 2'd0) return 4'(1 << off);
    if (s == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] d);
    if (s == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (s == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    if (s == 2'd0) return (w >> (8 * (a % 4))) & 32'hFF;
    if (s == 2'd1) return (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return w;
  endfunction

  function automatic logic [31:0] merge_store(input logic [1:0] s, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (s == 2'd0) begin
      sh = 8 * int'(a % 4);  mask = 32'hFF << sh;
    end else if (s == 2'd1) begin
      sh = 16 * int'((a / 2) % 2);  mask = 32'hFFFF << sh;
    end else begin
      sh = 0;  mask = 32'hFFFFFFFF;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    poke_en = 1'b1;  poke_idx = a[9:2];  poke_data = d;
    next_cycle();
    poke_en = 1'b0;
    exp_mem[a[9:2]] = d;
  endtask

  task automatic check_outputs_cleared(input string tag);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    check({tag, "_dones"}, {29'b0, if_done, dm_done, dm_err}, 32'h0);
    check({tag, "_stalls"}, {30'b0, if_stall, dm_stall}, 32'h0);
    check({tag, "_ram_ctl"}, {26'b0, ram_en, ram_we, ram_be}, 32'h0);
    check({tag, "_ram_addr"}, ram_addr, 32'h0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
  endtask

  // One data access from an idle port; checks RAM drive, latency, error and returned data.
  task automatic dm_op(input logic rw, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic bad;
    int   cyc, en_cyc;
    bad = is_bad(s, a);
    dm_req = 1'b1;  dm_rw = rw;  dm_size = s;  dm_addr = a;  dm_wdata = d;
    #1;
    check("dm_stall_wait", dm_stall, 1);
    cyc = 0;  en_cyc = 0;
    while (!dm_done && cyc < 20) begin
      next_cycle();
      cyc++;
      check("we_only_in_access", ram_we & ~ram_en, 0);
      if (ram_en) begin
        en_cyc++;
        check("dm_ram_addr", ram_addr, a & ~32'h3);
        check("dm_ram_be", ram_be, exp_lanes(s, a));
        check("dm_ram_we", ram_we, rw);
        if (rw) check("dm_ram_wdata", ram_wdata, exp_wdata(s, d));
      end
    end
    m_ptr_data = 1'b0;
    check("dm_latency", cyc, bad ? 1 : LAT + 1);
    check("dm_en_cycles", en_cyc, bad ? 0 : LAT);
    check("dm_err", dm_err, bad);
    if (!bad) begin
      if (rw) exp_mem[a[9:2]] = merge_store(s, a, exp_mem[a[9:2]], d);
      else    m_dm_rdata = exp_load(s, a, exp_mem[a[9:2]]);
    end
    check("dm_rdata", dm_rdata, m_dm_rdata);
    check("dm_stall_done", dm_stall, 0);
    dm_req = 1'b0;
    next_cycle();
    check("dm_done_one_cycle", dm_done, 0);
  endtask

  task automatic if_op(input logic [31:0] a);
    int cyc, en_cyc;
    if_req = 1'b1;  if_addr = a;
    #1;
    check("if_stall_wait", if_stall, 1);
    cyc = 0;  en_cyc = 0;
    while (!if_done && cyc < 20) begin
      next_cycle();
      cyc++;
      if (ram_en) begin
        en_cyc++;
        check("if_ram_addr", ram_addr, a & ~32'h3);
        check("if_ram_be_we", {27'b0, ram_we, ram_be}, 32'h0F);
      end
    end
    m_ptr_data = 1'b1;
    m_if_rdata = exp_mem[a[9:2]];
    check("if_latency", cyc, LAT + 1);
    check("if_en_cycles", en_cyc, LAT);
    check("if_rdata", if_rdata, m_if_rdata);
    check("if_stall_done", if_stall, 0);
    if_req = 1'b0;
    next_cycle();
  endtask

  // Fetch and word load raised together; the pointer decides who goes first.
  task automatic contend(input logic [31:0] fa, input logic [31:0] da);
    int cyc, t_if, t_dm, t_first, t_second;
    logic dm_first;
    dm_first = m_ptr_data;
    if_req = 1'b1;  if_addr = fa;
    dm_req = 1'b1;  dm_rw = 1'b0;  dm_size = 2'd2;  dm_addr = da;
    cyc = 0;  t_if = -1;  t_dm = -1;
    while ((t_if < 0 || t_dm < 0) && cyc < 30) begin
      next_cycle();
      cyc++;
      if (dm_done) begin
        t_dm = cyc;  dm_req = 1'b0;
        check("cont_dm_rdata", dm_rdata, exp_mem[da[9:2]]);
        check("cont_loser_if_stall", if_stall, t_if < 0);
      end
      if (if_done) begin
        t_if = cyc;  if_req = 1'b0;
        check("cont_if_rdata", if_rdata, exp_mem[fa[9:2]]);
        check("cont_loser_dm_stall", dm_stall, t_dm < 0);
      end
    end
    t_first  = LAT + 1;
    t_second = 2 * LAT + 3;
    check("cont_dm_time", t_dm, dm_first ? t_first : t_second);
    check("cont_if_time", t_if, dm_first ? t_second : t_first);
    m_dm_rdata = exp_mem[da[9:2]];
    m_if_rdata = exp_mem[fa[9:2]];
    m_ptr_data = dm_first;
    if_req = 1'b0;  dm_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int sel;
    logic [31:0] a;
    reset = 1'b1;  init_req = 1'b1;  poke_en = 1'b0;  poke_idx = '0;  poke_data = '0;
    if_req = 1'b0;  if_addr = '0;
    dm_req = 1'b0;  dm_rw = 1'b0;  dm_size = '0;  dm_addr = '0;  dm_wdata = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed_word(i);
    m_if_rdata = '0;  m_dm_rdata = '0;  m_ptr_data = 1'b1;
    next_cycle();
    init_req = 1'b0;
    next_cycle();
    check_outputs_cleared("reset");

    // Contention straight out of reset: data first, then fetch; repeat gives data first again.
    reset = 1'b0;
    contend(32'h0000_0040, 32'h0000_0080);
    contend(32'h0000_0044, 32'h0000_0084);

    poke(32'h104, 32'hE3A0_1005);
    if_op(32'h104);
    poke(32'h200, 32'h1234_ABCD);
    dm_op(1'b0, 2'd1, 32'h202, 32'h0);
    check("ld_half_0x202", dm_rdata, 32'h0000_1234);
    dm_op(1'b0, 2'd0, 32'h201, 32'h0);
    check("ld_byte_0x201", dm_rdata, 32'h0000_00AB);
    dm_op(1'b1, 2'd0, 32'h203, 32'h0000_00AB);
    check("st_byte_rdata_held", dm_rdata, 32'h0000_00AB);
    dm_op(1'b0, 2'd2, 32'h200, 32'h0);
    check("st_byte_merged", dm_rdata, 32'hAB34_ABCD);

    dm_op(1'b0, 2'd2, 32'h202, 32'h0);
    dm_op(1'b0, 2'd3, 32'h200, 32'h0);
    dm_op(1'b1, 2'd1, 32'h201, 32'hFFFF_FFFF);

    // Reset in the second ACCESS cycle of a store.
    dm_req = 1'b1;  dm_rw = 1'b1;  dm_size = 2'd2;  dm_addr = 32'h300;  dm_wdata = 32'hCAFE_F00D;
    next_cycle();
    next_cycle();
    check("rst_mid_en_before", {30'b0, ram_en, ram_we}, 32'h3);
    reset = 1'b1;  dm_req = 1'b0;
    #1;
    check_outputs_cleared("rst_mid");
    m_if_rdata = '0;  m_dm_rdata = '0;  m_ptr_data = 1'b1;
    next_cycle();
    check("rst_mid_no_done", {30'b0, dm_done, if_done}, 32'h0);
    reset = 1'b0;
    dm_op(1'b1, 2'd2, 32'h300, 32'hCAFE_F00D);
    dm_op(1'b0, 2'd2, 32'h300, 32'h0);
    check("rst_reissue_data", dm_rdata, 32'hCAFE_F00D);

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, 1023));
      if (sel <= 2)      if_op(a);
      else if (sel == 3) contend(a & ~32'h3, 32'($urandom_range(0, 255)) * 4);
      else               dm_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared memory port of the pipeline between the instruction-fetch stage and the data-memory stage. It accepts one request at a time and drives a fixed-latency single-port RAM. It generates byte-lane enables from the data access size and returns aligned, zero-extended load data. It also produces per-stage stall signals that the hazard logic uses to freeze IF or MEM while an access is outstanding.

## Interface
- MEM_LATENCY, 2, RAM read/write latency in cycles (legal 1..7)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address; bits [1:0] ignored
- if_rdata  out  32  fetched instruction, held until next fetch completes
- if_done  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_done (combinational)
- dm_req  in  1  data request (mem_enable), held until dm_done
- dm_rw  in  1  1 = store, 0 = load (mem_RW encoding)
- dm_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- dm_addr  in  32  byte address
- dm_wdata  in  32  store data, right-aligned
- dm_rdata  out  32  load data, zero-extended; held on stores and errors
- dm_done  out  1  one-cycle completion pulse for data
- dm_err  out  1  pulses with dm_done on misaligned or reserved-size access
- dm_stall  out  1  dm_req & ~dm_done (combinational)
- ram_en  out  1  RAM access active
- ram_we  out  1  RAM write
- ram_be  out  4  byte-lane enables, bit i = byte i (little-endian)
- ram_addr  out  32  word address, {addr[31:2],2'b00}
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data, valid at last ACCESS cycle

## Operation
- FSM states are IDLE, ACCESS, and RESP. Reset forces IDLE.
- Reset values: every output register is 0, and the priority pointer points to data.
- IDLE samples requests each edge.
  - Only one requester pending: select it.
  - Both pending: select per the priority pointer.
  - The pointer points to fetch after every data grant and to data after every fetch grant. The MEM-stage instruction therefore wins ties unless the previous grant was data.
- On grant, latch the address, rw, size, and wdata. The latched values drive ram_* for the whole ACCESS state. Fetch is always a word read with ram_be = 4'b1111.
- Data lanes:
  - Byte: be = 1<<addr[1:0], and wdata is {4{wdata[7:0]}}.
  - Halfword: be = addr[1] ? 1100 : 0011, and wdata is {2{wdata[15:0]}}.
  - Word: be = 1111.
- Misaligned or reserved accesses go IDLE→RESP directly, with no ram_en and dm_err = 1. Three cases qualify: halfword with addr[0] = 1, word with addr[1:0] ≠ 0, and size = 11.
- ACCESS behaviour:
  - ram_en stays high for exactly MEM_LATENCY cycles, using a 3-bit down-counter loaded with MEM_LATENCY-1.
  - When the counter reaches 0, register ram_rdata (loads and fetches) and go to RESP.
- Load extract: byte = {24'b0, lane[addr[1:0]]}, halfword = {16'b0, half[addr[1]]}, word = full.
- RESP lasts exactly one cycle.
  - Pulse the done of the granted requester.
  - Update if_rdata or dm_rdata on that same edge.
  - Return to IDLE. RESP does not sample requests.
- Requesters drop or replace req on the edge where done is seen. A req still high in IDLE is treated as a new request.

## Timing
- Granted at edge N (IDLE): ACCESS covers cycles N+1..N+MEM_LATENCY, and RESP (done = 1) is at cycle N+MEM_LATENCY+1.
- Latency from request to done is MEM_LATENCY+1 cycles. A misaligned access completes in 1 cycle.
- Throughput: one access per MEM_LATENCY+2 cycles.
- A request arriving while not in IDLE waits. Its stall stays asserted until its own done.
- Simultaneous requests in IDLE: the loser keeps its stall asserted and is granted on the next IDLE. Back-to-back contention therefore alternates strictly.
- Reset asserted mid-ACCESS: ram_en and ram_we drop immediately (asynchronously), no done is issued, and the pointer returns to data.
- ram_we is never high outside ACCESS.

## Test plan
- MEM_LATENCY = 2; fetch at 0x104 with RAM word 0xE3A01005 → ram_en high for 2 cycles, if_done at cycle 3, if_rdata = 0xE3A01005, if_stall low in cycle 3.
- Store byte 0xAB to 0x203 → ram_be = 1000, ram_wdata = 0xABABABAB, ram_addr = 0x200, ram_we = 1 for 2 cycles, dm_done at cycle 3, dm_rdata unchanged.
- Load halfword from 0x202 with RAM word 0x1234ABCD → dm_rdata = 0x00001234. Load byte from 0x201 with the same word → 0x000000AB.
- if_req and dm_req raised together from reset, both held → data is served first (dm_done at cycle 3), then fetch (if_done at cycle 7). Repeat the pair → data first again, because the pointer returned to data after the fetch grant.
- Word load from 0x202 → dm_done and dm_err pulse at cycle 1, ram_en never asserted. The same result holds for dm_size = 11.
- Assert reset in the second ACCESS cycle of a store → ram_en and ram_we fall with reset, no dm_done, and all outputs are 0. After release, a re-issued store completes normally.
